falafel_lsu_mp: RTL and testbench

- Parametrised successor of the falafel load/store unit for the free-list allocator.
- Executes header operations from the allocator core on the shared block memory: LOCK, UNLOCK, LOAD, EDIT_SIZE_AND_NEXT_ADDR, EDIT_NEXT_ADDR.
- Sits between the allocator core and the memory port.
- Adds a real compare-and-swap lock with a per-instance lock ID, CAS-failure retry, bounded retry with backoff, response status, and a parametrised header layout.

---
 rtl/falafel_lsu_mp.sv | 194 +++++++++++++++++++
 tb/tb_falafel_lsu_mp.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_lsu_mp.sv
// falafel_lsu_mp: free-list header load/store unit with CAS lock, bounded retry and backoff.
// Define FALAFEL_LSU_PERF_CNT_EN to add saturating op / failed-lock counters.
module falafel_lsu_mp #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] NEXT_ADDR_OFFSET = 8,
  parameter logic [DATA_W-1:0] EMPTY_KEY = 0,
  parameter logic [DATA_W-1:0] LOCK_ID = 1,
  parameter int unsigned MAX_RETRIES = 16,
  parameter int BACKOFF_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_val_i,
  output logic              core_req_rdy_o,
  input  logic [2:0]        core_req_op_i,
  input  logic [DATA_W-1:0] core_req_addr_i,
  input  logic [DATA_W-1:0] core_req_size_i,
  input  logic [DATA_W-1:0] core_req_next_addr_i,
  output logic              core_rsp_val_o,
  input  logic              core_rsp_rdy_i,
  output logic [1:0]        core_rsp_status_o,
  output logic [DATA_W-1:0] core_rsp_addr_o,
  output logic [DATA_W-1:0] core_rsp_size_o,
  output logic [DATA_W-1:0] core_rsp_next_addr_o,
  output logic              mem_req_val_o,
  input  logic              mem_req_rdy_i,
  output logic              mem_req_is_write_o,
  output logic              mem_req_is_cas_o,
  output logic [DATA_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  output logic [DATA_W-1:0] mem_req_cas_exp_o,
  input  logic              mem_rsp_val_i,
  output logic              mem_rsp_rdy_o,
  input  logic [DATA_W-1:0] mem_rsp_data_i,
  output logic [31:0]       perf_ops_o,
  output logic [31:0]       perf_cas_fail_o
);
  typedef enum logic [3:0] {
    IDLE, RD_KEY, CAS, BACKOFF, UNLOCK, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WAIT_MEM, RSP
  } state_e;
  localparam logic [1:0] ST_OK = 2'd0, ST_LF = 2'd1, ST_BAD = 2'd2;
  localparam logic [BACKOFF_W-1:0] BO_MAX = '1;
  state_e state_q, state_d, src_q, src_d, fl_s;
  logic [DATA_W-1:0] addr_q, addr_d, next_q, next_d, rsize_q, rsize_d, rnext_q, rnext_d;
  logic [DATA_W-1:0] maddr_q, maddr_d, mdata_q, mdata_d, mexp_q, mexp_d, a, n;
  logic mval_q, mval_d, mwe_q, mwe_d, mcas_q, mcas_d;
  logic [1:0] status_q, status_d;
  logic [31:0] retry_q, retry_d, retry_inc;
  logic [BACKOFF_W-1:0] bo_q, bo_d;
  logic iss, iss_d, mrsp, key_ok, fail, lim;
  assign iss = state_q inside {RD_KEY, CAS, UNLOCK, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT};
  assign iss_d = state_d inside {RD_KEY, CAS, UNLOCK, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT};
  assign mrsp = state_q == WAIT_MEM && mem_rsp_val_i;
  assign key_ok = mem_rsp_data_i == EMPTY_KEY;
  assign fail = mrsp && (src_q == RD_KEY || src_q == CAS) && !key_ok;
  assign retry_inc = retry_q + 32'd1;
  assign lim = MAX_RETRIES != 0 && retry_inc == MAX_RETRIES;
  assign fl_s = lim ? RSP : BACKOFF;
  // Request fields are built on entry to an issue state; from IDLE they come straight off the core port
  assign a = state_q == IDLE ? core_req_addr_i : addr_q;
  assign n = state_q == IDLE ? core_req_next_addr_i : next_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q <= IDLE;
      addr_q <= '0;
      next_q <= '0;
      rsize_q <= '0;
      rnext_q <= '0;
      status_q <= ST_OK;
      retry_q <= '0;
      bo_q <= '0;
      mval_q <= 1'b0;
      mwe_q <= 1'b0;
      mcas_q <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      mexp_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      addr_q <= addr_d;
      next_q <= next_d;
      rsize_q <= rsize_d;
      rnext_q <= rnext_d;
      status_q <= status_d;
      retry_q <= retry_d;
      bo_q <= bo_d;
      mval_q <= mval_d;
      mwe_q <= mwe_d;
      mcas_q <= mcas_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mexp_q <= mexp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    case (state_q)
      IDLE: if (core_req_val_i) state_d = core_req_op_i == 3'd0 ? RD_KEY :
                                          core_req_op_i == 3'd1 ? UNLOCK :
                                          core_req_op_i == 3'd2 ? RD_SIZE :
                                          core_req_op_i == 3'd3 ? WR_SIZE :
                                          core_req_op_i == 3'd4 ? WR_NEXT : RSP;
      BACKOFF: if (bo_q <= BACKOFF_W'(1)) state_d = RD_KEY;
      WAIT_MEM: if (mem_rsp_val_i) state_d = src_q == RD_KEY ? (key_ok ? CAS : fl_s) :
                                             src_q == CAS ? (key_ok ? RSP : fl_s) :
                                             src_q == RD_SIZE ? RD_NEXT :
                                             src_q == WR_SIZE ? WR_NEXT : RSP;
      RSP: if (core_rsp_rdy_i) state_d = IDLE;
      default: if (mem_req_rdy_i) begin
        state_d = WAIT_MEM;
        src_d = state_q;
      end
    endcase
  end
  always_comb begin
    addr_d = addr_q;
    next_d = next_q;
    rsize_d = rsize_q;
    rnext_d = rnext_q;
    status_d = status_q;
    retry_d = retry_q;
    bo_d = bo_q;
    mval_d = mval_q;
    mwe_d = mwe_q;
    mcas_d = mcas_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mexp_d = mexp_q;
    if (state_q == IDLE && core_req_val_i) begin
      addr_d = core_req_addr_i;
      next_d = core_req_next_addr_i;
      rsize_d = '0;
      rnext_d = '0;
      retry_d = '0;
      bo_d = '0;
      status_d = core_req_op_i > 3'd4 ? ST_BAD : ST_OK;
    end
    if (iss && mem_req_rdy_i) mval_d = 1'b0;
    if (state_q == BACKOFF) bo_d = bo_q - BACKOFF_W'(1);
    if (mrsp && src_q == RD_SIZE) rsize_d = mem_rsp_data_i;
    if (mrsp && src_q == RD_NEXT) rnext_d = mem_rsp_data_i;
    if (fail) begin
      retry_d = retry_inc;
      bo_d = retry_inc >= 32'(BO_MAX) ? BO_MAX : retry_inc[BACKOFF_W-1:0];
      status_d = lim ? ST_LF : status_q;
    end
    if (iss_d && state_d != state_q) begin
      mval_d = 1'b1;
      mwe_d = state_d inside {UNLOCK, WR_SIZE, WR_NEXT};
      mcas_d = state_d == CAS;
      maddr_d = state_d inside {RD_NEXT, WR_NEXT} ? a + NEXT_ADDR_OFFSET : a;
      mdata_d = state_d == CAS ? LOCK_ID : state_d == WR_SIZE ? core_req_size_i :
                state_d == WR_NEXT ? n : EMPTY_KEY;
      mexp_d = EMPTY_KEY;
    end
  end
  assign core_req_rdy_o = state_q == IDLE && !rst_i;
  assign core_rsp_val_o = state_q == RSP;
  assign core_rsp_status_o = status_q;
  assign core_rsp_addr_o = addr_q;
  assign core_rsp_size_o = rsize_q;
  assign core_rsp_next_addr_o = rnext_q;
  assign mem_req_val_o = mval_q;
  assign mem_req_is_write_o = mwe_q;
  assign mem_req_is_cas_o = mcas_q;
  assign mem_req_addr_o = maddr_q;
  assign mem_req_data_o = mdata_q;
  assign mem_req_cas_exp_o = mexp_q;
  assign mem_rsp_rdy_o = state_q == WAIT_MEM;
`ifdef FALAFEL_LSU_PERF_CNT_EN
  logic [31:0] ops_q, ops_d, cf_q, cf_d;
  always_comb begin
    ops_d = ops_q + 32'(core_rsp_val_o && core_rsp_rdy_i && ~&ops_q);
    cf_d = cf_q + 32'(fail && ~&cf_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ops_q <= '0;
      cf_q <= '0;
    end else begin
      ops_q <= ops_d;
      cf_q <= cf_d;
    end
  end
  assign perf_ops_o = ops_q;
  assign perf_cas_fail_o = cf_q;
`else
  assign perf_ops_o = '0;
  assign perf_cas_fail_o = '0;
`endif
endmodule

// File: tb/tb_falafel_lsu_mp.sv
// tb_falafel_lsu_mp: scoreboard bench for falafel_lsu_mp with a scripted memory model.
module tb_falafel_lsu_mp;
  localparam int W = 64;
`ifdef FALAFEL_LSU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic core_req_val_i, core_req_rdy_o, core_rsp_val_o, core_rsp_rdy_i;
  logic [2:0] core_req_op_i;
  logic [W-1:0] core_req_addr_i, core_req_size_i, core_req_next_addr_i;
  logic [1:0] core_rsp_status_o;
  logic [W-1:0] core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o;
  logic mem_req_val_o, mem_req_rdy_i, mem_req_is_write_o, mem_req_is_cas_o;
  logic [W-1:0] mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o, mem_rsp_data_i;
  logic mem_rsp_val_i, mem_rsp_rdy_o;
  logic [31:0] perf_ops_o, perf_cas_fail_o;
  typedef struct {logic we; logic cas; logic [W-1:0] addr; logic [W-1:0] data;} mreq_t;
  typedef struct {logic [1:0] st; logic [W-1:0] addr; logic [W-1:0] size; logic [W-1:0] next;} rsp_t;
  mreq_t mq[$];
  rsp_t rq[$];
  logic [W-1:0] rdq[$];
  int xt[$];
  int pass_n = 0, tot_n = 0, cyc = 0, stall = 0, hold = 0, rsp_delay = 0, n_xfer = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  falafel_lsu_mp #(.MAX_RETRIES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_val_i(core_req_val_i), .core_req_rdy_o(core_req_rdy_o),
    .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
    .core_req_size_i(core_req_size_i), .core_req_next_addr_i(core_req_next_addr_i),
    .core_rsp_val_o(core_rsp_val_o), .core_rsp_rdy_i(core_rsp_rdy_i),
    .core_rsp_status_o(core_rsp_status_o), .core_rsp_addr_o(core_rsp_addr_o),
    .core_rsp_size_o(core_rsp_size_o), .core_rsp_next_addr_o(core_rsp_next_addr_o),
    .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_is_write_o(mem_req_is_write_o), .mem_req_is_cas_o(mem_req_is_cas_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_cas_exp_o(mem_req_cas_exp_o), .mem_rsp_val_i(mem_rsp_val_i),
    .mem_rsp_rdy_o(mem_rsp_rdy_o), .mem_rsp_data_i(mem_rsp_data_i),
    .perf_ops_o(perf_ops_o), .perf_cas_fail_o(perf_cas_fail_o)
  );
  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  function automatic void cb(string nm, logic act, logic exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endfunction
  task automatic em(input logic we, input logic cas, input logic [W-1:0] a, input logic [W-1:0] d);
    mreq_t e;
    e.we = we;
    e.cas = cas;
    e.addr = a;
    e.data = d;
    mq.push_back(e);
  endtask
  task automatic er(input logic [1:0] st, input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] n);
    rsp_t r;
    r.st = st;
    r.addr = a;
    r.size = s;
    r.next = n;
    rq.push_back(r);
  endtask
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] n);
    logic ok;
    ok = 1'b0;
    core_req_val_i = 1'b1;
    core_req_op_i = op;
    core_req_addr_i = a;
    core_req_size_i = s;
    core_req_next_addr_i = n;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = core_req_rdy_o;
    end
    cb("req_accept", ok, 1'b1);
    @(posedge clk_i);
    #1 core_req_val_i = 1'b0;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 300 && (rq.size() != 0 || mq.size() != 0); i++) @(posedge clk_i);
    chk("drain", W'(rq.size() + mq.size()), 0);
    @(posedge clk_i);
    #1;
  endtask
  initial begin : monitor
    mreq_t e;
    rsp_t r;
    logic held;
    logic [W-1:0] ha, hd;
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      if (held) begin
        cb("req_hold_val", mem_req_val_o, 1'b1);
        chk("req_hold_addr", mem_req_addr_o, ha);
        chk("req_hold_data", mem_req_data_o, hd);
      end
      held = mem_req_val_o && !mem_req_rdy_i;
      ha = mem_req_addr_o;
      hd = mem_req_data_o;
      if (mem_req_val_o && mem_req_rdy_i) begin
        n_xfer++;
        xt.push_back(cyc);
        if (mq.size() == 0) cb("mem_unexpected", 1'b1, 1'b0);
        else begin
          e = mq.pop_front();
          cb("mem_we", mem_req_is_write_o, e.we);
          cb("mem_cas", mem_req_is_cas_o, e.cas);
          chk("mem_addr", mem_req_addr_o, e.addr);
          if (e.we || e.cas) chk("mem_data", mem_req_data_o, e.data);
          if (e.cas) chk("mem_cas_exp", mem_req_cas_exp_o, 0);
        end
      end
      if (core_rsp_val_o && core_rsp_rdy_i) begin
        if (rq.size() == 0) cb("rsp_unexpected", 1'b1, 1'b0);
        else begin
          r = rq.pop_front();
          chk("rsp_status", W'(core_rsp_status_o), W'(r.st));
          chk("rsp_addr", core_rsp_addr_o, r.addr);
          chk("rsp_size", core_rsp_size_o, r.size);
          chk("rsp_next", core_rsp_next_addr_o, r.next);
        end
      end
    end
  end
  initial begin : env
    int cnt;
    logic pend, xr, xs, wr;
    logic [W-1:0] d;
    cnt = 0;
    pend = 1'b0;
    d = '0;
    mem_req_rdy_i = 1'b1;
    mem_rsp_val_i = 1'b0;
    mem_rsp_data_i = '0;
    core_rsp_rdy_i = 1'b1;
    forever begin
      @(negedge clk_i);
      xr = mem_req_val_o && mem_req_rdy_i && !rst_i;
      xs = mem_rsp_val_i && mem_rsp_rdy_o;
      wr = mem_req_is_write_o;
      @(posedge clk_i);
      #1;
      if (xs) mem_rsp_val_i = 1'b0;
      if (xr) begin
        pend = 1'b1;
        cnt = rsp_delay;
        d = wr ? 64'hdead : (rdq.size() != 0 ? rdq.pop_front() : 64'hbad);
      end
      if (rst_i) begin
        pend = 1'b0;
        mem_rsp_val_i = 1'b0;
      end
      if (pend) begin
        if (cnt == 0) begin
          mem_rsp_val_i = 1'b1;
          mem_rsp_data_i = d;
          pend = 1'b0;
        end else cnt--;
      end
      mem_req_rdy_i = !(mem_req_val_o && stall > 0);
      if (mem_req_val_o && stall > 0) stall--;
      core_rsp_rdy_i = !(core_rsp_val_o && hold > 0);
      if (core_rsp_val_o && hold > 0) hold--;
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin : stim
    int nx;
    core_req_val_i = 1'b0;
    core_req_op_i = '0;
    core_req_addr_i = '0;
    core_req_size_i = '0;
    core_req_next_addr_i = '0;
    #12;
    cb("rst_req_rdy", core_req_rdy_o, 1'b0);
    cb("rst_mem_val", mem_req_val_o, 1'b0);
    cb("rst_rsp_val", core_rsp_val_o, 1'b0);
    chk("rst_perf_ops", W'(perf_ops_o), 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    cb("idle_req_rdy", core_req_rdy_o, 1'b1);
    @(posedge clk_i);
    #1;
    rdq.push_back('h40);
    rdq.push_back('h200);
    em(0, 0, 'h100, 0);
    em(0, 0, 'h108, 0);
    er(0, 'h100, 'h40, 'h200);
    hold = 2;
    send(3'd2, 'h100, 0, 0);
    wait_done();
    em(1, 0, 'h80, 'h20);
    em(1, 0, 'h88, 'h300);
    er(0, 'h80, 0, 0);
    stall = 3;
    send(3'd3, 'h80, 'h20, 'h300);
    wait_done();
    rdq.push_back(0);
    rdq.push_back(0);
    em(0, 0, 'h40, 0);
    em(0, 1, 'h40, 1);
    er(0, 'h40, 0, 0);
    send(3'd0, 'h40, 0, 0);
    wait_done();
    chk("perf_cf_lock_ok", W'(perf_cas_fail_o), 0);
    repeat (3) begin
      rdq.push_back(5);
      em(0, 0, 'h40, 0);
    end
    er(1, 'h40, 0, 0);
    xt.delete();
    send(3'd0, 'h40, 0, 0);
    wait_done();
    chk("backoff_gap1", W'(xt[1] - xt[0]), 3);
    chk("backoff_gap2", W'(xt[2] - xt[1]), 4);
    chk("perf_cf_fail3", W'(perf_cas_fail_o), PERF ? 3 : 0);
    rdq.push_back(0);
    rdq.push_back(7);
    rdq.push_back(0);
    rdq.push_back(0);
    em(0, 0, 'h48, 0);
    em(0, 1, 'h48, 1);
    em(0, 0, 'h48, 0);
    em(0, 1, 'h48, 1);
    er(0, 'h48, 0, 0);
    xt.delete();
    send(3'd0, 'h48, 0, 0);
    wait_done();
    chk("cas_retry_gap", W'(xt[2] - xt[1]), 3);
    chk("perf_cf_cas", W'(perf_cas_fail_o), PERF ? 4 : 0);
    em(1, 0, 'h40, 0);
    er(0, 'h40, 0, 0);
    send(3'd1, 'h40, 0, 0);
    wait_done();
    em(1, 0, 'h1008, 'h55);
    er(0, 'h1000, 0, 0);
    send(3'd4, 'h1000, 'h99, 'h55);
    wait_done();
    nx = n_xfer;
    er(2, 'h77, 0, 0);
    send(3'd6, 'h77, 'h1, 'h2);
    wait_done();
    er(2, 'h78, 0, 0);
    send(3'd5, 'h78, 'h1, 'h2);
    wait_done();
    chk("bad_op_no_mem", W'(n_xfer - nx), 0);
    chk("perf_ops9", W'(perf_ops_o), PERF ? 9 : 0);
    rdq.push_back('h1);
    rdq.push_back('h2);
    em(0, 0, 64'hffff_ffff_ffff_fffc, 0);
    em(0, 0, 'h4, 0);
    er(0, 64'hffff_ffff_ffff_fffc, 'h1, 'h2);
    send(3'd2, 64'hffff_ffff_ffff_fffc, 0, 0);
    wait_done();
    rsp_delay = 6;
    em(0, 0, 'h500, 0);
    send(3'd2, 'h500, 0, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    cb("pre_rst_wait_mem", mem_rsp_rdy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    cb("async_rst_outputs", |{core_req_rdy_o, core_rsp_val_o, core_rsp_status_o, core_rsp_addr_o,
                              core_rsp_size_o, core_rsp_next_addr_o, mem_req_val_o, mem_req_is_write_o,
                              mem_req_is_cas_o, mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o,
                              mem_rsp_rdy_o, perf_ops_o, perf_cas_fail_o}, 1'b0);
    chk("rst_mem_xfer_done", W'(mq.size()), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    rsp_delay = 0;
    @(posedge clk_i);
    #1;
    rdq.push_back('h11);
    rdq.push_back('h22);
    em(0, 0, 'h300, 0);
    em(0, 0, 'h308, 0);
    er(0, 'h300, 'h11, 'h22);
    send(3'd2, 'h300, 0, 0);
    wait_done();
    chk("perf_ops_after_rst", W'(perf_ops_o), PERF ? 1 : 0);
    chk("perf_cf_after_rst", W'(perf_cas_fail_o), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
